// File: rtl/ysyx_25040101_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040101_mem_arbiter_pkg
//  Description : Shared encodings and bus widths for the IFU/LSU memory
//                arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_25040101_mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_25040101_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040101_mem_arbiter_if
//  Description : Bundle of the upstream IFU/LSU channels and the downstream
//                memory port. "slave" is the arbiter's view, "master" is the
//                view of the environment (requesters plus memory).
//  Revision    : 1.0  initial release
// ============================================================================
interface ysyx_25040101_mem_arbiter_if;
    import ysyx_25040101_mem_arbiter_pkg::*;

    // IFU channel
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_rsp_valid;
    logic              ifu_rsp_err;

    // LSU channel
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic              lsu_wen;
    logic [DATA_W-1:0] lsu_wdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              lsu_rsp_valid;
    logic              lsu_rsp_err;

    // Shared read data for both response channels
    logic [DATA_W-1:0] rsp_rdata;

    // Downstream memory port
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        output ifu_req_ready, ifu_rsp_valid, ifu_rsp_err,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_err,
        output rsp_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
        input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_err,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_err,
        input  rsp_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

endinterface
`default_nettype wire

// File: rtl/ysyx_25040101_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25040101_mem_arbiter
//  Description : Shares one memory port between IFU and LSU with a single
//                transaction in flight, round-robin on ties, and a response
//                timeout that returns an error to the owner.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_25040101_mem_arbiter
    import ysyx_25040101_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    ysyx_25040101_mem_arbiter_if.slave     bus
);

    localparam int               c_CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_CNT = c_CNT_W'(TIMEOUT);

    state_t              r_state;
    grant_t              r_last_grant;
    grant_t              r_grant;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                r_mem_req_valid;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_wen;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [MASK_W-1:0]   r_mem_wmask;

    grant_t              w_sel;
    logic                w_accept;
    logic                w_in_wait;
    logic                w_timeout;
    logic                w_rsp_fire;
    logic                w_rsp_err;

    // Round-robin pick: a tie goes to whoever was not served last
    always_comb begin
        w_sel = GNT_IFU;
        if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            w_sel = (r_last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU;
        end else if (bus.lsu_req_valid) begin
            w_sel = GNT_LSU;
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && (bus.ifu_req_valid || bus.lsu_req_valid);
    assign w_in_wait  = (r_state == ST_WAIT);
    assign w_timeout  = (r_cnt == c_TIMEOUT_CNT);
    // A real response in the timeout cycle takes priority over the error
    assign w_rsp_fire = w_in_wait && (bus.mem_rsp_valid || w_timeout);
    assign w_rsp_err  = w_in_wait && !bus.mem_rsp_valid && w_timeout;

    // Transaction FSM: latch on grant, hold the request until accepted, then wait
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_last_grant    <= GNT_IFU;
            r_grant         <= GNT_IFU;
            r_cnt           <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wen       <= 1'b0;
            r_mem_wdata     <= '0;
            r_mem_wmask     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state         <= ST_REQ;
                        r_last_grant    <= w_sel;
                        r_grant         <= w_sel;
                        r_mem_req_valid <= 1'b1;
                        if (w_sel == GNT_LSU) begin
                            r_mem_addr  <= bus.lsu_addr;
                            r_mem_wen   <= bus.lsu_wen;
                            r_mem_wdata <= bus.lsu_wdata;
                            r_mem_wmask <= bus.lsu_wmask;
                        end else begin
                            // Instruction fetch is always a full-word read
                            r_mem_addr  <= bus.ifu_addr;
                            r_mem_wen   <= 1'b0;
                            r_mem_wdata <= '0;
                            r_mem_wmask <= '1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_state         <= ST_WAIT;
                        r_mem_req_valid <= 1'b0;
                        r_cnt           <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_rsp_fire) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ifu_req_ready = w_accept && (w_sel == GNT_IFU);
    assign bus.lsu_req_ready = w_accept && (w_sel == GNT_LSU);

    assign bus.ifu_rsp_valid = w_rsp_fire && (r_grant == GNT_IFU);
    assign bus.lsu_rsp_valid = w_rsp_fire && (r_grant == GNT_LSU);
    assign bus.ifu_rsp_err   = w_rsp_err  && (r_grant == GNT_IFU);
    assign bus.lsu_rsp_err   = w_rsp_err  && (r_grant == GNT_LSU);
    assign bus.rsp_rdata     = (w_in_wait && bus.mem_rsp_valid) ? bus.mem_rsp_rdata : '0;

    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wen       = r_mem_wen;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.mem_wmask     = r_mem_wmask;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040101_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_25040101_mem_arbiter
//  Description : Directed bench for the IFU/LSU memory arbiter. Stimulus
//                pushes expected grants and responses into queues; a monitor
//                on the falling edge pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_25040101_mem_arbiter;
    import ysyx_25040101_mem_arbiter_pkg::*;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ysyx_25040101_mem_arbiter_if bus();

    ysyx_25040101_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        owner;   // 0 = IFU, 1 = LSU
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t rsp_q[$];
    logic gnt_q[$];

    int   checks = 0;
    int   errors = 0;
    bit   ok;
    rsp_t m_exp;
    logic m_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_rsp(input logic owner, input logic err, input logic [31:0] rdata);
        rsp_t e;
        e.owner = owner;
        e.err   = err;
        e.rdata = rdata;
        rsp_q.push_back(e);
    endtask

    // Monitor: compares every grant and every response pulse against the queues
    always @(negedge clk) begin
        if (bus.ifu_req_ready || bus.lsu_req_ready) begin
            if (gnt_q.size() == 0) begin
                chk("unexpected_grant", {30'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 32'd0);
            end else begin
                m_gnt = gnt_q.pop_front();
                chk("grant_owner", {30'd0, bus.ifu_req_ready, bus.lsu_req_ready},
                    m_gnt ? 32'd1 : 32'd2);
            end
        end
        if (bus.ifu_rsp_valid || bus.lsu_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", {30'd0, bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 32'd0);
            end else begin
                m_exp = rsp_q.pop_front();
                chk("rsp_owner", {30'd0, bus.ifu_rsp_valid, bus.lsu_rsp_valid},
                    m_exp.owner ? 32'd1 : 32'd2);
                chk("rsp_err", {30'd0, bus.ifu_rsp_err, bus.lsu_rsp_err},
                    m_exp.err ? (m_exp.owner ? 32'd1 : 32'd2) : 32'd0);
                chk("rsp_rdata", bus.rsp_rdata, m_exp.rdata);
            end
        end else begin
            chk("idle_rsp_rdata", bus.rsp_rdata, 32'd0);
            chk("idle_rsp_err", {30'd0, bus.ifu_rsp_err, bus.lsu_rsp_err}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present one request for a single cycle, then scramble the inputs
    task automatic issue(input logic owner, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask);
        if (owner) begin
            bus.lsu_req_valid = 1'b1;
            bus.lsu_addr      = addr;
            bus.lsu_wen       = wen;
            bus.lsu_wdata     = wdata;
            bus.lsu_wmask     = wmask;
        end else begin
            bus.ifu_req_valid = 1'b1;
            bus.ifu_addr      = addr;
        end
        gnt_q.push_back(owner);
        @(negedge clk);
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.ifu_addr      = 32'hFFFF_FFF0;
        bus.lsu_addr      = 32'hFFFF_FFFC;
        bus.lsu_wen       = ~wen;
        bus.lsu_wdata     = ~wdata;
        bus.lsu_wmask     = ~wmask;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.mem_req_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("mem_req_seen", {31'd0, got}, 32'd1);
    endtask

    // Memory side of one transaction: hold off for 'stall' cycles, accept,
    // then answer after 'dly' idle WAIT cycles
    task automatic serve(input logic owner, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input int stall, input int dly, input logic [31:0] rdata);
        bit got;
        wait_req(got);
        if (!got) return;
        for (int s = 0; s <= stall; s++) begin
            chk("mem_addr", bus.mem_addr, addr);
            chk("mem_wdata", bus.mem_wdata, wdata);
            chk("mem_ctl", {26'd0, bus.mem_req_valid, bus.mem_wen, bus.mem_wmask},
                {26'd0, 1'b1, wen, wmask});
            if (s < stall) @(negedge clk);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        repeat (dly) tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = rdata;
        push_rsp(owner, 1'b0, rdata);
        @(negedge clk);
        chk("rsp_pulse", {31'd0, owner ? bus.lsu_rsp_valid : bus.ifu_rsp_valid}, 32'd1);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.ifu_req_valid = 1'b0;
        bus.ifu_addr      = 32'd0;
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = 32'd0;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = 32'd0;
        bus.lsu_wmask     = 4'd0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_mem_ctl", {26'd0, bus.mem_req_valid, bus.mem_wen, bus.mem_wmask}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_ready", {30'd0, bus.ifu_req_ready, bus.lsu_req_ready}, 32'd0);
        chk("rst_rsp", {28'd0, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
                        bus.ifu_rsp_err, bus.lsu_rsp_err}, 32'd0);
        tick();

        // Single IFU read, minimum turnaround
        issue(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'd0);
        serve(1'b0, 32'h8000_0000, 1'b0, 32'd0, 4'hF, 0, 0, 32'h0000_0413);

        // LSU store held stable through 3 stall cycles
        issue(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011);
        serve(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 3, 1, 32'hCAFE_0000);

        // Simultaneous requests after reset: LSU, IFU, LSU, IFU
        do_reset();
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h8000_0010;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h8000_2000;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = 32'd0;
        bus.lsu_wmask     = 4'hF;
        gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0);
        serve(1'b1, 32'h8000_2000, 1'b0, 32'd0, 4'hF, 0, 0, 32'h0000_0100);
        serve(1'b0, 32'h8000_0010, 1'b0, 32'd0, 4'hF, 1, 1, 32'h0000_0101);
        // response lands in the timeout cycle: must not be an error
        serve(1'b1, 32'h8000_2000, 1'b0, 32'd0, 4'hF, 0, TIMEOUT, 32'h0000_0102);
        serve(1'b0, 32'h8000_0010, 1'b0, 32'd0, 4'hF, 0, 2, 32'h0000_0103);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;

        // Timeout with no response, then a late response that must be ignored
        issue(1'b1, 32'h8000_3000, 1'b0, 32'd0, 4'hF);
        wait_req(ok);
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_req_ready = 1'b0;
        push_rsp(1'b1, 1'b1, 32'd0);
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            chk("to_valid", {31'd0, bus.lsu_rsp_valid}, (k == TIMEOUT) ? 32'd1 : 32'd0);
            chk("to_err", {31'd0, bus.lsu_rsp_err}, (k == TIMEOUT) ? 32'd1 : 32'd0);
            tick();
        end
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0000_0055;
        @(negedge clk);
        chk("late_rsp_valid", {30'd0, bus.ifu_rsp_valid, bus.lsu_rsp_valid}, 32'd0);
        chk("late_rsp_rdata", bus.rsp_rdata, 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;

        // Reset while in WAIT drops the transaction
        issue(1'b0, 32'h8000_0020, 1'b0, 32'd0, 4'd0);
        wait_req(ok);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h0000_0077;
        #1;
        chk("mid_rst_state", {30'd0, dut.r_state}, {30'd0, ST_IDLE});
        chk("mid_rst_mem", {26'd0, bus.mem_req_valid, bus.mem_wen, bus.mem_wmask}, 32'd0);
        chk("mid_rst_addr", bus.mem_addr, 32'd0);
        chk("mid_rst_rsp", {28'd0, bus.ifu_rsp_valid, bus.lsu_rsp_valid,
                            bus.ifu_rsp_err, bus.lsu_rsp_err}, 32'd0);
        chk("mid_rst_rdata", bus.rsp_rdata, 32'd0);
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'd0;
        tick();
        rst = 1'b0;
        issue(1'b0, 32'h8000_0040, 1'b0, 32'd0, 4'd0);
        serve(1'b0, 32'h8000_0040, 1'b0, 32'd0, 4'hF, 0, 2, 32'h0000_ABCD);

        repeat (3) tick();
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        chk("gnt_q_drained", gnt_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_25040101_mem_arbiter.md
# ysyx_25040101_mem_arbiter

Two-requester memory arbiter that shares one memory port between the instruction fetch path (IFU) and the load/store path (LSU) of the ysyx_25040101 core. It holds at most one transaction in flight. A three-state FSM latches the granted request, presents it downstream, and routes the response back to its owner. A response timeout guarantees forward progress if the memory never answers.

## Interface
Parameters:
- TIMEOUT, default 255: number of cycles waited in WAIT before an error response is generated; legal range 1 to 65535. Counter width is $clog2(TIMEOUT+1).

Ports:
- Reset is asynchronous and active-high; the clock is clk and the reset is rst.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- ifu_req_valid / lsu_req_valid  in  1  request pending
- ifu_req_ready / lsu_req_ready  out  1  request accepted this cycle
- ifu_addr / lsu_addr  in  32  byte address
- lsu_wen  in  1  1 = store, 0 = load; IFU requests are always reads
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  byte enables
- ifu_rsp_valid / lsu_rsp_valid  out  1  one-cycle response pulse
- ifu_rsp_err / lsu_rsp_err  out  1  response is a timeout error
- rsp_rdata  out  32  read data, shared by both response channels
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream request accepted
- mem_addr  out  32  latched address
- mem_wen  out  1  latched write enable
- mem_wdata  out  32  latched store data
- mem_wmask  out  4  latched byte enables
- mem_rsp_valid  in  1  downstream response valid; has no backpressure
- mem_rsp_rdata  in  32  downstream read data

## Operation
- FSM states: IDLE, REQ, WAIT. Reset values:
  - state = IDLE, last_grant = IFU, counter = 0.
  - All mem_* outputs, ready outputs, rsp_valid outputs and rsp_err outputs are 0.
- IDLE, selecting a requester:
  - If only one requester is valid, select it.
  - If both are valid, select the requester other than last_grant. After reset the first tie therefore goes to the LSU.
- IDLE, on a selection:
  - The selected requester's req_ready is driven combinationally high.
  - On that clock edge: latch addr, wen, wdata and wmask. For an IFU grant, wen=0, wdata=0 and wmask=4'hF.
  - Record the grant in last_grant and go to REQ.
- REQ:
  - mem_req_valid=1 with the latched fields, which stay stable until the request is accepted.
  - On mem_req_ready=1, go to WAIT and clear the counter.
- WAIT:
  - Counter increments by 1 each cycle.
  - On mem_rsp_valid=1, combinationally assert the granted requester's rsp_valid with rsp_err=0 and rsp_rdata=mem_rsp_rdata, then go to IDLE.
  - If counter == TIMEOUT and mem_rsp_valid=0, assert the granted requester's rsp_valid with rsp_err=1 and rsp_rdata=0, then go to IDLE.
- rsp_rdata is 0 whenever no response is being delivered.
- Boundary conditions:
  - mem_rsp_valid in IDLE or REQ, including a late response after a timeout: ignored, no upstream pulse.
  - Response and timeout in the same cycle: the response wins, rsp_err=0.
  - A requester dropping req_valid after acceptance has no effect on the latched transaction.
  - Reset mid-transaction: the transaction is dropped immediately and no response is produced.

## Timing
- Request accepted in cycle N, which is the req_ready cycle. mem_req_valid is high from N+1.
- With mem_req_ready in N+1 and mem_rsp_valid in N+2, the upstream rsp_valid pulses in N+2. Minimum turnaround is 3 cycles per transaction.
- The next request can be accepted in the cycle after the response (N+3).
- The response path is combinational from mem_rsp_* to the upstream outputs. The request path is fully registered.
- Timeout fires TIMEOUT+1 cycles after entry to WAIT.

## Structure
- The shared package holds:
  - the state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2;
  - the grant encoding: IFU=1'b0, LSU=1'b1;
  - the bus widths: ADDR_W=32, DATA_W=32, MASK_W=4.
- No sub-modules; the single round-robin select is inline logic.

## Test plan
- **Single IFU read.** IFU requests addr 0x80000000; memory gives ready immediately and rdata 0x00000413 the next cycle. Required: ifu_rsp_valid pulses in cycle 2 with that data, lsu_rsp_valid stays 0.
- **LSU store.** LSU stores wdata 0xDEADBEEF, wmask 4'b0011 to addr 0x80001000. Required: mem_wen=1 and the fields are held stable while mem_req_ready is low for 3 cycles; lsu_rsp_valid pulses on the response.
- **Simultaneous requests after reset.** Both requesters valid continuously. Required: grant order LSU, IFU, LSU, IFU; each req_ready is high exactly once per grant.
- **Timeout.** TIMEOUT=4 and memory never responds. Required: lsu_rsp_valid=1 and lsu_rsp_err=1 with rsp_rdata=0, 5 cycles after WAIT entry. A late mem_rsp_valid afterwards produces no pulse.
- **Reset mid-transaction.** Assert rst while in WAIT. Required: state returns to IDLE the same cycle, all outputs are 0, and the following IFU request completes normally.
